pad_ctrl_regs: RTL and testbench

//  Per-pad control/status register bank inside chip_core, directly upstream of the bidir pad ring.
//  - Drives every bidir pad control: out/oe/cs/sl/ie/pu/pd.
//  - Selects per pad between software-driven output and a peripheral function output.
//  - Two-flop synchronises pad inputs; records sticky rise/fall events.
//  - Programmed over a simple valid/ready config bus from the core CPU.

---
 rtl/pad_ctrl_regs.sv | 160 ++++++++++++++++
 tb/tb_pad_ctrl_regs.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_ctrl_regs.sv
// Per-pad control/status register bank for the bidir pad ring: valid/ready config bus,
// software/peripheral output mux, two-flop input synchroniser and sticky edge flags.
module pad_ctrl_regs #(
  parameter int unsigned NUM_BIDIR_PADS = 40,
  parameter int unsigned ADDR_W         = 6,
  parameter bit          RST_IE         = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_we,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [10:0]               cfg_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [10:0]               rsp_rdata,
  output logic                      rsp_err,
  input  logic [NUM_BIDIR_PADS-1:0] func_out,
  input  logic [NUM_BIDIR_PADS-1:0] func_oe,
  output logic [NUM_BIDIR_PADS-1:0] func_in,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd
);
  localparam int unsigned N = NUM_BIDIR_PADS;

  logic [N-1:0] oe_q, oe_d, cs_q, cs_d, sl_q, sl_d, ie_q, ie_d;
  logic [N-1:0] pu_q, pu_d, pd_q, pd_d, out_q, out_d, fsel_q, fsel_d;
  logic [N-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [N-1:0] rise_q, rise_d, fall_q, fall_d;
  logic         rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [10:0]  rsp_rdata_q, rsp_rdata_d;

  logic [N-1:0] sel, wr_hit;
  logic         addr_ok, accept;
  logic [10:0]  rd_word;
  logic         unused_wdata8;

  // Bit 8 (IN) is read-only; writes to it are ignored.
  assign unused_wdata8 = cfg_wdata[8];

  // Address decode; out-of-range addresses leave sel empty and addr_ok low.
  always_comb begin
    sel     = '0;
    addr_ok = 1'b0;
    rd_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cfg_addr == ADDR_W'(i)) begin
        sel[i]  = 1'b1;
        addr_ok = 1'b1;
        rd_word = {fall_q[i], rise_q[i], sync2_q[i], fsel_q[i], out_q[i], pd_q[i], pu_q[i],
                   ie_q[i], sl_q[i], cs_q[i], oe_q[i]};
      end
    end
  end

  assign accept = cfg_valid & ~rsp_valid_q;
  assign wr_hit = sel & {N{accept & cfg_we}};

  always_comb begin
    oe_d   = oe_q;
    cs_d   = cs_q;
    sl_d   = sl_q;
    ie_d   = ie_q;
    pu_d   = pu_q;
    pd_d   = pd_q;
    out_d  = out_q;
    fsel_d = fsel_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (wr_hit[i]) begin
        oe_d[i]   = cfg_wdata[0];
        cs_d[i]   = cfg_wdata[1];
        sl_d[i]   = cfg_wdata[2];
        ie_d[i]   = cfg_wdata[3];
        pu_d[i]   = cfg_wdata[4];
        pd_d[i]   = cfg_wdata[5];
        out_d[i]  = cfg_wdata[6];
        fsel_d[i] = cfg_wdata[7];
      end
    end

    sync1_d = bidir_in & ie_q;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // New edges are OR-ed in after the clear so a coincident event keeps the flag set.
    rise_d  = (rise_q & ~(wr_hit & {N{cfg_wdata[9]}}))  | (sync2_q & ~prev_q);
    fall_d  = (fall_q & ~(wr_hit & {N{cfg_wdata[10]}})) | (~sync2_q & prev_q);

    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = ~addr_ok;
      rsp_rdata_d = (cfg_we || !addr_ok) ? 11'd0 : rd_word;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oe_q        <= '0;
      cs_q        <= '0;
      sl_q        <= '0;
      ie_q        <= {N{RST_IE}};
      pu_q        <= '0;
      pd_q        <= '0;
      out_q       <= '0;
      fsel_q      <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      oe_q        <= oe_d;
      cs_q        <= cs_d;
      sl_q        <= sl_d;
      ie_q        <= ie_d;
      pu_q        <= pu_d;
      pd_q        <= pd_d;
      out_q       <= out_d;
      fsel_q      <= fsel_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cfg_ready = ~rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign bidir_out = (fsel_q & func_out) | (~fsel_q & out_q);
  assign bidir_oe  = (fsel_q & func_oe)  | (~fsel_q & oe_q);
  assign bidir_cs  = cs_q;
  assign bidir_sl  = sl_q;
  assign bidir_ie  = ie_q;
  assign bidir_pu  = pu_q;
  // Pull-up wins when both pulls are requested.
  assign bidir_pd  = pd_q & ~pu_q;
  assign func_in   = sync2_q;

endmodule

// File: tb/tb_pad_ctrl_regs.sv
// Self-checking bench for pad_ctrl_regs: directed vector table, hand-written corner
// sequences and a randomized phase compared against a behavioural model.
module tb_pad_ctrl_regs;
  localparam int N  = 40;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n, cfg_valid, cfg_ready, cfg_we, rsp_valid, rsp_ready, rsp_err;
  logic [AW-1:0] cfg_addr;
  logic [10:0]   cfg_wdata, rsp_rdata;
  logic [N-1:0]  func_out, func_oe, func_in, bidir_in;
  logic [N-1:0]  bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;

  int checks   = 0;
  int failures = 0;

  pad_ctrl_regs #(.NUM_BIDIR_PADS(N), .ADDR_W(AW), .RST_IE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .func_out(func_out), .func_oe(func_oe), .func_in(func_in), .bidir_in(bidir_in),
    .bidir_out(bidir_out), .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
    .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model: register bytes, sticky flags, and a history of gated pad samples
  // (samp[0] = sampled at the latest edge, samp[1] = one edge earlier, ...).
  logic [7:0]   m_reg [N];
  logic [N-1:0] m_rise, m_fall;
  logic [N-1:0] samp[$];
  bit           m_pend, m_err;
  logic [10:0]  m_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = 8'h08;
    m_rise = '0;
    m_fall = '0;
    samp.delete();
    repeat (3) samp.push_back('0);
    m_pend  = 0;
    m_err   = 0;
    m_rdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [N-1:0] ie_now, s, rs, fs, seen;
    int idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) ie_now[i] = m_reg[i][3];
    s    = bidir_in & ie_now;
    seen = samp[1];
    rs   = samp[1] & ~samp[2];
    fs   = ~samp[1] & samp[2];
    idx  = int'(cfg_addr);
    if (cfg_valid && !m_pend) begin
      m_pend = 1;
      if (idx >= N) begin
        m_err   = 1;
        m_rdata = '0;
      end else if (cfg_we) begin
        m_err      = 0;
        m_rdata    = '0;
        m_reg[idx] = cfg_wdata[7:0];
        if (cfg_wdata[9])  m_rise[idx] = 1'b0;
        if (cfg_wdata[10]) m_fall[idx] = 1'b0;
      end else begin
        m_err   = 0;
        m_rdata = {m_fall[idx], m_rise[idx], seen[idx], m_reg[idx]};
      end
    end else if (m_pend && rsp_ready) begin
      m_pend = 0;
    end
    m_rise = m_rise | rs;
    m_fall = m_fall | fs;
    samp.push_front(s);
    void'(samp.pop_back());
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic [N-1:0] e_out, e_oe, e_cs, e_sl, e_ie, e_pu, e_pd;
    logic [7:0] r;
    for (int i = 0; i < N; i++) begin
      r        = m_reg[i];
      e_out[i] = r[7] ? func_out[i] : r[6];
      e_oe[i]  = r[7] ? func_oe[i]  : r[0];
      e_cs[i]  = r[1];
      e_sl[i]  = r[2];
      e_ie[i]  = r[3];
      e_pu[i]  = r[4];
      e_pd[i]  = r[5] & ~r[4];
    end
    chk("rnd_out", bidir_out, e_out);
    chk("rnd_oe", bidir_oe, e_oe);
    chk("rnd_cs", bidir_cs, e_cs);
    chk("rnd_sl", bidir_sl, e_sl);
    chk("rnd_ie", bidir_ie, e_ie);
    chk("rnd_pu", bidir_pu, e_pu);
    chk("rnd_pd", bidir_pd, e_pd);
    chk("rnd_func_in", func_in, samp[1]);
    chk("rnd_cfg_ready", cfg_ready, !m_pend);
    chk("rnd_rsp_valid", rsp_valid, m_pend);
    if (m_pend) begin
      chk("rnd_rdata", rsp_rdata, m_rdata);
      chk("rnd_err", rsp_err, m_err);
    end
  endtask

  // One full transaction: wait for ready, hand over, then consume and check the response.
  task automatic do_txn(input string name, input bit we, input logic [AW-1:0] addr,
                        input logic [10:0] wdata, input logic [10:0] exp_rdata,
                        input bit exp_err);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    rsp_ready = 1'b0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cfg_ready) begin
      chk({name, "_ready_timeout"}, cfg_ready, 1);
      cfg_valid = 1'b0;
      return;
    end
    tick();
    cfg_valid = 1'b0;
    chk({name, "_rsp_valid"}, rsp_valid, 1);
    chk({name, "_rdata"}, rsp_rdata, exp_rdata);
    chk({name, "_err"}, rsp_err, exp_err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({name, "_ready_after"}, cfg_ready, 1);
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [10:0]   wdata;
    logic [10:0]   rdata;
    bit            err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{we: 1, addr: 6'd5,  wdata: 11'h041, rdata: 11'h000, err: 0};
    vecs[1] = '{we: 0, addr: 6'd5,  wdata: 11'h000, rdata: 11'h041, err: 0};
    vecs[2] = '{we: 0, addr: 6'd63, wdata: 11'h000, rdata: 11'h000, err: 1};
    vecs[3] = '{we: 1, addr: 6'd40, wdata: 11'h0ff, rdata: 11'h000, err: 1};
    vecs[4] = '{we: 0, addr: 6'd39, wdata: 11'h000, rdata: 11'h008, err: 0};
    vecs[5] = '{we: 1, addr: 6'd3,  wdata: 11'h080, rdata: 11'h000, err: 0};
    vecs[6] = '{we: 0, addr: 6'd3,  wdata: 11'h000, rdata: 11'h080, err: 0};
    vecs[7] = '{we: 1, addr: 6'd10, wdata: 11'h030, rdata: 11'h000, err: 0};
    vecs[8] = '{we: 0, addr: 6'd10, wdata: 11'h000, rdata: 11'h030, err: 0};
    vecs[9] = '{we: 0, addr: 6'd0,  wdata: 11'h000, rdata: 11'h008, err: 0};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    rsp_ready = 1'b0; func_out = '0; func_oe = '0; bidir_in = '0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    chk("reset_oe", bidir_oe, 0);
    chk("reset_pu", bidir_pu, 0);
    chk("reset_pd", bidir_pd, 0);
    chk("reset_ie", bidir_ie, {N{1'b1}});
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_cfg_ready", cfg_ready, 1);
    chk("reset_rdata", rsp_rdata, 0);
    rst_n = 1'b1;

    foreach (vecs[k]) do_txn($sformatf("vec%0d", k), vecs[k].we, vecs[k].addr,
                             vecs[k].wdata, vecs[k].rdata, vecs[k].err);

    chk("w5_oe", bidir_oe[5], 1);
    chk("w5_out", bidir_out[5], 1);
    chk("w5_ie", bidir_ie[5], 0);
    chk("pupd_pu", bidir_pu[10], 1);
    chk("pupd_pd", bidir_pd[10], 0);
    do_txn("pd_only", 1, 6'd11, 11'h020, 11'h000, 0);
    chk("pd_only_pd", bidir_pd[11], 1);

    func_out[3] = 1'b1;
    func_oe[3]  = 1'b1;
    #1;
    chk("fsel_out", bidir_out[3], 1);
    chk("fsel_oe", bidir_oe[3], 1);
    do_txn("fsel_clr", 1, 6'd3, 11'h000, 11'h000, 0);
    chk("fsel_clr_out", bidir_out[3], 0);
    chk("fsel_clr_oe", bidir_oe[3], 0);

    // Edge capture on pad 7 (IE still at reset value).
    bidir_in[7] = 1'b1;
    tick();
    chk("sync_1clk", func_in[7], 0);
    tick();
    chk("sync_2clk", func_in[7], 1);
    tick();
    do_txn("rise_rd", 0, 6'd7, 11'h000, 11'h308, 0);
    do_txn("rise_w1c", 1, 6'd7, 11'h208, 11'h000, 0);
    do_txn("rise_cleared", 0, 6'd7, 11'h000, 11'h108, 0);
    bidir_in[7] = 1'b0;
    repeat (4) tick();
    do_txn("both_w1c", 1, 6'd7, 11'h608, 11'h000, 0);
    do_txn("both_cleared", 0, 6'd7, 11'h000, 11'h008, 0);
    // Rising edge lands on the same clock as the W1C write: the flag must survive.
    bidir_in[7] = 1'b1;
    tick();
    tick();
    do_txn("coincide_w1c", 1, 6'd7, 11'h208, 11'h000, 0);
    do_txn("coincide_rd", 0, 6'd7, 11'h000, 11'h308, 0);

    // Backpressure: response held, and a further request must not be taken.
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = 6'd63; rsp_ready = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 11'h000;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_err", rsp_err, 1);
      chk("bp_rdata", rsp_rdata, 0);
      chk("bp_cfg_ready", cfg_ready, 0);
      tick();
    end
    cfg_valid = 1'b0;
    chk("bp_no_write", bidir_oe[5], 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_ready_back", cfg_ready, 1);
    chk("bp_valid_gone", rsp_valid, 0);

    // Reset while a response is pending.
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = 6'd5;
    tick();
    cfg_valid = 1'b0;
    chk("rstmid_pending", rsp_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("rstmid_valid", rsp_valid, 0);
    chk("rstmid_ready", cfg_ready, 1);
    chk("rstmid_rdata", rsp_rdata, 0);
    chk("rstmid_oe", bidir_oe, 0);
    chk("rstmid_pu", bidir_pu, 0);
    chk("rstmid_ie", bidir_ie, {N{1'b1}});
    rst_n = 1'b1;
    tick();
    check_model();

    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_we    = 1'($urandom_range(0, 1));
      cfg_addr  = AW'($urandom_range(0, 63));
      cfg_wdata = 11'($urandom());
      rsp_ready = 1'($urandom_range(0, 1));
      bidir_in  = N'({$urandom(), $urandom()});
      func_out  = N'({$urandom(), $urandom()});
      func_oe   = N'({$urandom(), $urandom()});
      tick();
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
